calendar_date_counter: RTL and testbench

CALENDAR_DATE_COUNTER -- requirements
Module: calendar_date_counter

---
 rtl/calendar_pkg.sv | 30 +++
 rtl/cal_month_len.sv | 19 +
 rtl/calendar_date_counter.sv | 154 +++++++++++++++
 tb/tb_calendar_date_counter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared encodings, limits and reset values for the calendar date counter.
// Also hosts the leap-year rule so every file applies the same one.
package calendar_pkg;

  typedef enum logic [1:0] {
    SEL_DAY   = 2'b00,
    SEL_MONTH = 2'b01,
    SEL_YEAR  = 2'b10,
    SEL_RSVD  = 2'b11
  } sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [4:0] DAY_MAX   = 5'd31;
  localparam logic [3:0] MONTH_MAX = 4'd12;
  localparam logic [6:0] YEAR_MAX  = 7'd99;

  localparam logic [4:0] RST_DAY   = 5'd1;
  localparam logic [3:0] RST_MONTH = 4'd1;
  localparam logic [6:0] RST_YEAR  = 7'd0;

  // Years are offsets from 2000, so mod-4 alone is exact over 2000..2099.
  function automatic logic is_leap(input logic [6:0] yr);
    return (yr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/cal_month_len.sv
// Combinational month-length lookup: (month, leap) -> number of days.
module cal_month_len
  import calendar_pkg::*;
(
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] mdays
);

  always_comb begin
    mdays = DAY_MAX;
    case (month)
      4'd2:                      mdays = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   mdays = 5'd30;
      default:                   mdays = DAY_MAX;
    endcase
  end

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year counter advanced by day_tick, loadable field by field, with a
// one-deep pending register so a tick colliding with a load is not dropped.
module calendar_date_counter
  import calendar_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic [6:0] set_val,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic       leap,
  output logic       century_wrap,
  output logic       set_err,
  output logic       tick_lost,
  output state_e     state_dbg
);

  logic [4:0] day_q, day_d;
  logic [3:0] month_q, month_d;
  logic [6:0] year_q, year_d;
  logic       leap_q, leap_d;
  logic       cw_q, cw_d;
  logic       err_q, err_d;
  logic       lost_q, lost_d;
  state_e     state_q, state_d;

  logic [3:0] cand_month;
  logic       cand_leap;
  logic [4:0] cur_mdays, cand_mdays;
  logic       load_ok;
  logic [4:0] clamped_day;

  cal_month_len u_len_cur (
    .month (month_q),
    .leap  (leap_q),
    .mdays (cur_mdays)
  );

  cal_month_len u_len_cand (
    .month (cand_month),
    .leap  (cand_leap),
    .mdays (cand_mdays)
  );

  // Candidate month/leap reflect what the date would be after the load.
  always_comb begin
    cand_month = month_q;
    cand_leap  = leap_q;
    load_ok    = 1'b0;
    case (sel_e'(set_sel))
      SEL_DAY:   load_ok = (set_val >= 7'd1) && (set_val <= {2'b00, cand_mdays});
      SEL_MONTH: begin
        cand_month = set_val[3:0];
        load_ok    = (set_val >= 7'd1) && (set_val <= {3'b000, MONTH_MAX});
      end
      SEL_YEAR: begin
        cand_leap = is_leap(set_val);
        load_ok   = (set_val <= YEAR_MAX);
      end
      default:   load_ok = 1'b0;
    endcase
    clamped_day = (day_q > cand_mdays) ? cand_mdays : day_q;
  end

  always_comb begin
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    cw_d    = 1'b0;
    err_d   = 1'b0;
    lost_d  = 1'b0;
    state_d = state_q;

    if (set_en) begin
      if (load_ok) begin
        case (sel_e'(set_sel))
          SEL_DAY:   day_d = set_val[4:0];
          SEL_MONTH: begin
            month_d = cand_month;
            day_d   = clamped_day;
          end
          SEL_YEAR: begin
            year_d = set_val;
            day_d  = clamped_day;
          end
          default: ;
        endcase
      end else begin
        err_d = 1'b1;
      end
      if (day_tick) begin
        lost_d  = (state_q == ST_HOLD);
        state_d = ST_HOLD;
      end
    end else if ((state_q == ST_HOLD) || day_tick) begin
      // The held tick goes first; a fresh tick in the same cycle stays pending.
      if (day_q < cur_mdays) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d = 5'd1;
        if (month_q == MONTH_MAX) begin
          month_d = 4'd1;
          if (year_q == YEAR_MAX) begin
            year_d = 7'd0;
            cw_d   = 1'b1;
          end else begin
            year_d = year_q + 7'd1;
          end
        end else begin
          month_d = month_q + 4'd1;
        end
      end
      state_d = ((state_q == ST_HOLD) && day_tick) ? ST_HOLD : ST_IDLE;
    end

    leap_d = is_leap(year_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q   <= RST_DAY;
      month_q <= RST_MONTH;
      year_q  <= RST_YEAR;
      leap_q  <= 1'b1;
      cw_q    <= 1'b0;
      err_q   <= 1'b0;
      lost_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      leap_q  <= leap_d;
      cw_q    <= cw_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
      state_q <= state_d;
    end
  end

  assign day          = day_q;
  assign month        = month_q;
  assign year         = year_q;
  assign leap         = leap_q;
  assign century_wrap = cw_q;
  assign set_err      = err_q;
  assign tick_lost    = lost_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed bench for calendar_date_counter with hand-computed expected dates.
module tb_calendar_date_counter;
  import calendar_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       day_tick = 1'b0;
  logic       set_en = 1'b0;
  logic [1:0] set_sel = 2'b00;
  logic [6:0] set_val = 7'd0;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic       leap;
  logic       century_wrap;
  logic       set_err;
  logic       tick_lost;
  state_e     state_dbg;

  int n_vec = 0;
  int n_err = 0;

  calendar_date_counter dut (
    .clk          (clk),
    .rst          (rst),
    .day_tick     (day_tick),
    .set_en       (set_en),
    .set_sel      (set_sel),
    .set_val      (set_val),
    .day          (day),
    .month        (month),
    .year         (year),
    .leap         (leap),
    .century_wrap (century_wrap),
    .set_err      (set_err),
    .tick_lost    (tick_lost),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_date(input string tag, input int d, input int m, input int y);
    check({tag, ".day"},   32'(day),   32'(d));
    check({tag, ".month"}, 32'(month), 32'(m));
    check({tag, ".year"},  32'(year),  32'(y));
  endtask

  // Drive one cycle of inputs at the falling edge; outputs settle #1 after rise.
  task automatic step(input logic r, input logic t, input logic e,
                      input logic [1:0] sel, input logic [6:0] val);
    @(negedge clk);
    rst = r; day_tick = t; set_en = e; set_sel = sel; set_val = val;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'b00, 7'd0);
  endtask

  task automatic tick();
    step(1'b0, 1'b1, 1'b0, 2'b00, 7'd0);
  endtask

  task automatic load(input logic [1:0] sel, input logic [6:0] val);
    step(1'b0, 1'b0, 1'b1, sel, val);
  endtask

  // Year first, then month, then day, so each load sees the final month length.
  task automatic set_date(input int d, input int m, input int y);
    load(SEL_YEAR, 7'(y));
    load(SEL_MONTH, 7'(m));
    load(SEL_DAY, 7'(d));
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b1, 2'b01, 7'd5);
    step(1'b1, 1'b0, 1'b0, 2'b00, 7'd0);
    idle();
    check_date("reset", 1, 1, 0);
    check("reset.leap", 32'(leap), 32'd1);
    check("reset.cw", 32'(century_wrap), 32'd0);
    check("reset.err", 32'(set_err), 32'd0);
    check("reset.lost", 32'(tick_lost), 32'd0);
    check("reset.state", 32'(state_dbg), 32'(ST_IDLE));

    set_date(28, 2, 24);
    check_date("preset_leap", 28, 2, 24);
    tick();
    check_date("leap_feb29", 29, 2, 24);
    check("leap_feb29.leap", 32'(leap), 32'd1);
    tick();
    check_date("leap_mar1", 1, 3, 24);

    set_date(28, 2, 23);
    check("nonleap.leap", 32'(leap), 32'd0);
    tick();
    check_date("nonleap_mar1", 1, 3, 23);

    set_date(30, 4, 23);
    tick();
    check_date("apr_roll", 1, 5, 23);

    set_date(31, 12, 99);
    check("cw_pre", 32'(century_wrap), 32'd0);
    tick();
    check_date("century", 1, 1, 0);
    check("century.cw", 32'(century_wrap), 32'd1);
    check("century.leap", 32'(leap), 32'd1);
    idle();
    check("century.cw_drop", 32'(century_wrap), 32'd0);

    set_date(31, 1, 23);
    check_date("clamp_pre", 31, 1, 23);
    load(SEL_MONTH, 7'd2);
    check_date("clamp", 28, 2, 23);
    check("clamp.err", 32'(set_err), 32'd0);

    set_date(30, 4, 23);
    load(SEL_DAY, 7'd31);
    check_date("bad_day31", 30, 4, 23);
    check("bad_day31.err", 32'(set_err), 32'd1);
    idle();
    check("bad_day31.err_drop", 32'(set_err), 32'd0);
    load(SEL_RSVD, 7'd3);
    check_date("bad_sel", 30, 4, 23);
    check("bad_sel.err", 32'(set_err), 32'd1);
    load(SEL_MONTH, 7'd13);
    check("bad_month13.err", 32'(set_err), 32'd1);
    load(SEL_YEAR, 7'd100);
    check("bad_year100.err", 32'(set_err), 32'd1);
    load(SEL_DAY, 7'd0);
    check_date("bad_day0", 30, 4, 23);
    check("bad_day0.err", 32'(set_err), 32'd1);
    load(SEL_YEAR, 7'd99);
    check_date("good_year99", 30, 4, 99);
    check("good_year99.err", 32'(set_err), 32'd0);

    set_date(10, 5, 30);
    step(1'b0, 1'b1, 1'b1, SEL_DAY, 7'd20);
    check_date("collide", 20, 5, 30);
    check("collide.state", 32'(state_dbg), 32'(ST_HOLD));
    idle();
    check_date("collide_apply", 21, 5, 30);
    check("collide_apply.state", 32'(state_dbg), 32'(ST_IDLE));
    idle();
    check_date("collide_quiet", 21, 5, 30);

    step(1'b0, 1'b1, 1'b1, SEL_DAY, 7'd5);
    check("lost_pre", 32'(tick_lost), 32'd0);
    step(1'b0, 1'b1, 1'b1, SEL_DAY, 7'd7);
    check_date("lost", 7, 5, 30);
    check("lost.pulse", 32'(tick_lost), 32'd1);
    check("lost.state", 32'(state_dbg), 32'(ST_HOLD));
    idle();
    check_date("lost_apply", 8, 5, 30);
    check("lost.drop", 32'(tick_lost), 32'd0);
    check("lost_apply.state", 32'(state_dbg), 32'(ST_IDLE));

    step(1'b0, 1'b1, 1'b1, SEL_DAY, 7'd10);
    tick();
    check_date("double_first", 11, 5, 30);
    check("double_first.state", 32'(state_dbg), 32'(ST_HOLD));
    idle();
    check_date("double_second", 12, 5, 30);
    check("double_second.state", 32'(state_dbg), 32'(ST_IDLE));

    step(1'b0, 1'b1, 1'b1, SEL_DAY, 7'd15);
    check("rst_hold.pre", 32'(state_dbg), 32'(ST_HOLD));
    step(1'b1, 1'b1, 1'b1, SEL_DAY, 7'd3);
    check_date("rst_hold", 1, 1, 0);
    check("rst_hold.state", 32'(state_dbg), 32'(ST_IDLE));
    idle();
    idle();
    idle();
    check_date("rst_hold_after", 1, 1, 0);
    check("rst_hold_after.lost", 32'(tick_lost), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
